// File: rtl/vga_write_arbiter.sv
// Round-robin burst arbiter sharing one VGA adapter write port between N_REQ pixel renderers.
// A grant lasts a whole burst; a watchdog reclaims the port from a silent grantee.
module vga_write_arbiter #(
    parameter int N_REQ   = 4,
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int C_W     = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     done,
    input  logic [N_REQ-1:0]     in_we,
    input  logic [N_REQ*X_W-1:0] in_x,
    input  logic [N_REQ*Y_W-1:0] in_y,
    input  logic [N_REQ*C_W-1:0] in_colour,
    output logic [N_REQ-1:0]     grant,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y,
    output logic [C_W-1:0]       colour,
    output logic                 writeEn,
    output logic                 busy,
    output logic                 drop_err,
    output logic                 timeout_err
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t           state_r;
    logic [N_REQ-1:0] grant_r;
    logic [IDX_W-1:0] last_r;
    logic [IDX_W-1:0] g_idx_r;
    logic [WD_W-1:0]  wd_r;
    logic [X_W-1:0]   x_r;
    logic [Y_W-1:0]   y_r;
    logic [C_W-1:0]   colour_r;
    logic             we_r;
    logic             busy_r;
    logic             drop_err_r;
    logic             timeout_err_r;

    logic [IDX_W-1:0] winner_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;
    logic             g_we_s;
    logic             g_done_s;
    logic [X_W-1:0]   g_x_s;
    logic [Y_W-1:0]   g_y_s;
    logic [C_W-1:0]   g_colour_s;
    logic             stray_s;

    // Round-robin winner: first asserted req scanning from last_r+1 upward, wrapping.
    always_comb begin
        winner_s = last_r;
        cand_s   = last_r;
        found_s  = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_s = IDX_W'((int'(last_r) + i) % N_REQ);
            if (!found_s && req[cand_s]) begin
                winner_s = cand_s;
                found_s  = 1'b1;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    assign g_we_s     = in_we[g_idx_r];
    assign g_done_s   = done[g_idx_r];
    assign g_x_s      = in_x[int'(g_idx_r)*X_W +: X_W];
    assign g_y_s      = in_y[int'(g_idx_r)*Y_W +: Y_W];
    assign g_colour_s = in_colour[int'(g_idx_r)*C_W +: C_W];
    // grant_r is zero in IDLE, so any pixel offered there counts as stray.
    assign stray_s    = |(in_we & ~grant_r);

    // Arbitration FSM, pixel pass-through register, watchdog and sticky error flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= IDLE;
            grant_r       <= '0;
            last_r        <= IDX_LAST;
            g_idx_r       <= '0;
            wd_r          <= '0;
            x_r           <= '0;
            y_r           <= '0;
            colour_r      <= '0;
            we_r          <= 1'b0;
            busy_r        <= 1'b0;
            drop_err_r    <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            if (stray_s) begin
                drop_err_r <= 1'b1;
            end else begin
                drop_err_r <= drop_err_r;
            end
            case (state_r)
                IDLE: begin
                    we_r <= 1'b0;
                    wd_r <= '0;
                    if (found_s) begin
                        state_r <= BURST;
                        grant_r <= onehot(winner_s);
                        last_r  <= winner_s;
                        g_idx_r <= winner_s;
                        busy_r  <= 1'b1;
                    end else begin
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                BURST: begin
                    if (g_we_s) begin
                        we_r     <= 1'b1;
                        x_r      <= g_x_s;
                        y_r      <= g_y_s;
                        colour_r <= g_colour_s;
                    end else begin
                        we_r <= 1'b0;
                    end
                    // done wins over the watchdog; any pixel from the grantee rearms it.
                    if (g_done_s) begin
                        state_r <= IDLE;
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                        wd_r    <= '0;
                    end else if (g_we_s) begin
                        wd_r <= '0;
                    end else if (wd_r == WD_LAST) begin
                        state_r       <= IDLE;
                        grant_r       <= '0;
                        busy_r        <= 1'b0;
                        wd_r          <= '0;
                        timeout_err_r <= 1'b1;
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                    we_r    <= 1'b0;
                    wd_r    <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign x           = x_r;
    assign y           = y_r;
    assign colour      = colour_r;
    assign writeEn     = we_r;
    assign busy        = busy_r;
    assign drop_err    = drop_err_r;
    assign timeout_err = timeout_err_r;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// Self-checking bench for vga_write_arbiter: per-cycle vector table plus pixel scoreboard,
// with hand-written timeout and asynchronous-reset sequences.
module tb_vga_write_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic [3:0]   req, done, in_we;
    logic [35:0]  in_x;
    logic [31:0]  in_y;
    logic [11:0]  in_colour;
    logic [3:0]   grant;
    logic [8:0]   x;
    logic [7:0]   y;
    logic [2:0]   colour;
    logic         writeEn, busy, drop_err, timeout_err;

    vga_write_arbiter #(.N_REQ(N), .X_W(9), .Y_W(8), .C_W(3), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn), .req(req), .done(done), .in_we(in_we),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .grant(grant),
        .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy),
        .drop_err(drop_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req, done, we;
        int         slot;
        logic [8:0] px;
        logic [7:0] py;
        logic [2:0] pc;
        logic [3:0] eg;
        logic       ewe, ebusy, edrop;
    } vec_t;

    typedef struct {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    vec_t vecs[$];
    pix_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic [3:0] cur_g_m = 4'b0000;

    function automatic vec_t mk(input logic [3:0] r, d, w, input int s,
                                input int px, py, pc, input logic [3:0] eg,
                                input logic ewe, eb, ed);
        vec_t v;
        v.req = r; v.done = d; v.we = w; v.slot = s;
        v.px = 9'(px); v.py = 8'(py); v.pc = 3'(pc);
        v.eg = eg; v.ewe = ewe; v.ebusy = eb; v.edrop = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, d, w, input int s,
                         input logic [8:0] px, input logic [7:0] py, input logic [2:0] pc);
        req = r; done = d; in_we = w;
        in_x = '0; in_y = '0; in_colour = '0;
        in_x[s*9 +: 9] = px;
        in_y[s*8 +: 8] = py;
        in_colour[s*3 +: 3] = pc;
    endtask

    task automatic push(input logic [8:0] px, input logic [7:0] py, input logic [2:0] pc);
        pix_t p;
        p.x = px; p.y = py; p.c = pc;
        sb.push_back(p);
    endtask

    // Every written pixel must match the oldest expected one.
    task automatic observe();
        pix_t p;
        if (writeEn === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_write", 32'd1, 32'd0);
            end else begin
                p = sb.pop_front();
                chk("pix_x", 32'(x), 32'(p.x));
                chk("pix_y", 32'(y), 32'(p.y));
                chk("pix_c", 32'(colour), 32'(p.c));
            end
        end
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000, 0, 9'd0, 8'd0, 3'd0);
        // single request, 3 pixels, done
        vecs.push_back(mk(4'b0001, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0001, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0000, 4'b0001, 0,  10,  20, 5, 4'b0001, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0000, 4'b0001, 0,  11,  20, 5, 4'b0001, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0000, 4'b0001, 0,  12,  20, 5, 4'b0001, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0001, 4'b0000, 0,   0,   0, 0, 4'b0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(4'b0000, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0000, 1'b0, 1'b0, 1'b0));
        // round-robin with req=1111 held, 1-pixel bursts
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0010, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0010, 4'b0010, 1, 100,   1, 1, 4'b0000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0100, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0100, 4'b0100, 2, 101,   2, 2, 4'b0000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b1000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b1000, 4'b1000, 3, 102,   3, 3, 4'b0000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0001, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0001, 4'b0001, 0, 103,   4, 4, 4'b0000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0010, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b1111, 4'b0010, 4'b0010, 1, 104,   5, 5, 4'b0000, 1'b1, 1'b0, 1'b0));
        // pixel from a non-granted requester is dropped and flagged
        vecs.push_back(mk(4'b0001, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0001, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(4'b0001, 4'b0000, 4'b0100, 2,  50,  60, 7, 4'b0001, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(4'b0001, 4'b0001, 4'b0000, 0,   0,   0, 0, 4'b0000, 1'b0, 1'b0, 1'b1));
        // done together with the last pixel
        vecs.push_back(mk(4'b0010, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0010, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(4'b0010, 4'b0010, 4'b0010, 1, 319, 239, 3, 4'b0000, 1'b1, 1'b0, 1'b1));
        // req drop and foreign done do not end a burst
        vecs.push_back(mk(4'b0100, 4'b0000, 4'b0000, 0,   0,   0, 0, 4'b0100, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0001, 4'b0000, 0,   0,   0, 0, 4'b0100, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(4'b0000, 4'b0100, 4'b0000, 0,   0,   0, 0, 4'b0000, 1'b0, 1'b0, 1'b1));

        repeat (2) tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(writeEn), 32'd0);
        chk("rst_xyc", {x, y, colour}, 32'd0);
        chk("rst_errs", {drop_err, timeout_err}, 32'd0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].done, vecs[i].we, vecs[i].slot,
                  vecs[i].px, vecs[i].py, vecs[i].pc);
            if ((vecs[i].we & cur_g_m) != 4'b0000) push(vecs[i].px, vecs[i].py, vecs[i].pc);
            cur_g_m = vecs[i].eg;
            tick();
            observe();
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].eg));
            chk($sformatf("v%0d_we", i), 32'(writeEn), 32'(vecs[i].ewe));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].ebusy));
            chk($sformatf("v%0d_drop", i), 32'(drop_err), 32'(vecs[i].edrop));
        end

        // watchdog: one pixel, then silence; release on the 8th silent edge
        drive(4'b1001, 4'b0000, 4'b0000, 0, 9'd0, 8'd0, 3'd0);
        tick();
        chk("to_grant", 32'(grant), 32'b1000);
        drive(4'b1001, 4'b0000, 4'b1000, 3, 9'd5, 8'd6, 3'd1);
        push(9'd5, 8'd6, 3'd1);
        tick();
        observe();
        chk("to_pix_we", 32'(writeEn), 32'd1);
        drive(4'b1001, 4'b0000, 4'b0000, 0, 9'd0, 8'd0, 3'd0);
        n = 0;
        while (n < 20 && grant !== 4'b0000) begin
            tick();
            observe();
            n++;
            if (n == 7) chk("to_err_early", 32'(timeout_err), 32'd0);
        end
        chk("to_silent_cycles", n, 32'd8);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        tick();
        chk("to_next_grant", 32'(grant), 32'b0001);
        drive(4'b0000, 4'b0001, 4'b0000, 0, 9'd0, 8'd0, 3'd0);
        tick();
        chk("to_release", 32'(grant), 32'd0);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);

        // asynchronous reset mid-burst
        drive(4'b0001, 4'b0000, 4'b0000, 0, 9'd0, 8'd0, 3'd0);
        tick();
        chk("ar_grant", 32'(grant), 32'b0001);
        drive(4'b0001, 4'b0000, 4'b0001, 0, 9'd7, 8'd8, 3'd2);
        push(9'd7, 8'd8, 3'd2);
        tick();
        observe();
        drive(4'b0001, 4'b0000, 4'b0001, 0, 9'd9, 8'd9, 3'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_grant0", 32'(grant), 32'd0);
        chk("ar_we0", 32'(writeEn), 32'd0);
        chk("ar_busy0", 32'(busy), 32'd0);
        chk("ar_errs0", {drop_err, timeout_err}, 32'd0);
        drive(4'b0000, 4'b0000, 4'b0000, 0, 9'd0, 8'd0, 3'd0);
        tick();
        observe();
        resetn = 1'b1;
        drive(4'b1001, 4'b0000, 4'b0000, 0, 9'd0, 8'd0, 3'd0);
        tick();
        observe();
        chk("ar_prio0", 32'(grant), 32'b0001);
        drive(4'b0000, 4'b0001, 4'b0000, 0, 9'd0, 8'd0, 3'd0);
        tick();
        observe();
        chk("ar_release", 32'(grant), 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
